ft245_tx_arbiter: RTL

- Round-robin arbiter and framer that shares the single ft245 host-bound write FIFO (wren/wrdata/wrfifo_full) among N_REQ on-chip packet sources.
- Each granted burst is preceded by a header word identifying the source, sequence number and continuation status.
- Sits in the clk_40mhz domain directly in front of the ft245 FPGA-side write port; the PC-side demultiplexer relies on the framing defined here.

---
 rtl/ft245_tx_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ft245_tx_arbiter.sv
// Round-robin arbiter/framer sharing the ft245 write FIFO among N_REQ sources.
// Define FT245_TX_ARB_TRAILER_EN to append a checksum trailer after each burst.
module ft245_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        wren,
    output logic [DATA_WIDTH-1:0]       wrdata,
    input  logic                        wrfifo_full,
    output logic [7:0]                  grant_id,
    output logic                        busy
);
    localparam int IDXW = $clog2(N_REQ);
    localparam int CW   = $clog2(MAX_BURST + 1);

`ifdef FT245_TX_ARB_TRAILER_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    state_t state, state_nxt;

    logic [IDXW-1:0]       grant;
    logic [IDXW-1:0]       last;
    logic [IDXW-1:0]       pick;
    logic [6:0]            seq;
    logic [N_REQ-1:0]      cont;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_inc;
    logic                  hdr_wr;
    logic                  xfer;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid source strictly after 'from', wrapping around.
    function automatic logic [IDXW-1:0] rr_pick(
        input logic [N_REQ-1:0] v,
        input logic [IDXW-1:0]  from
    );
        logic [IDXW-1:0] sel;
        logic            found;
        int              idx;
        sel   = from;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(from) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && v[IDXW'(idx)]) begin
                found = 1'b1;
                sel   = IDXW'(idx);
            end
        end
        return sel;
    endfunction

`ifdef FT245_TX_ARB_TRAILER_EN
    localparam int LANES = (DATA_WIDTH + 15) / 16;

    logic [15:0] csum;

    function automatic logic [15:0] fold(input logic [DATA_WIDTH-1:0] w);
        logic [LANES*16-1:0] p;
        logic [15:0]         x;
        p                 = '0;
        p[DATA_WIDTH-1:0] = w;
        x                 = '0;
        for (int l = 0; l < LANES; l++) begin
            x = x ^ p[l*16 +: 16];
        end
        return x;
    endfunction
`endif

    assign pick      = rr_pick(req_valid, last);
    assign count_inc = count + 1'b1;
    assign burst_end = req_last[grant] || (count_inc == CW'(MAX_BURST));
    assign busy      = (state != IDLE);
    assign grant_id  = 8'(grant);

    always_comb begin
        state_nxt = state;
        wren      = 1'b0;
        wrdata    = '0;
        req_ready = '0;
        hdr_wr    = 1'b0;
        xfer      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                wren          = !wrfifo_full;
                wrdata[31:0]  = {16'hA55A, grant_id, seq, cont[grant]};
                if (!wrfifo_full) begin
                    hdr_wr    = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                req_ready[grant] = !wrfifo_full;
                xfer             = req_valid[grant] & !wrfifo_full;
                wren             = xfer;
                wrdata           = data_arr[grant];
                if (xfer && burst_end) begin
`ifdef FT245_TX_ARB_TRAILER_EN
                    state_nxt = TRL;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef FT245_TX_ARB_TRAILER_EN
            TRL: begin
                wren         = !wrfifo_full;
                wrdata[31:0] = {16'h5AA5, csum};
                if (!wrfifo_full) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            last  <= IDXW'(N_REQ - 1);
            seq   <= '0;
            cont  <= '0;
            count <= '0;
`ifdef FT245_TX_ARB_TRAILER_EN
            csum  <= '0;
`endif
        end else begin
            if (state == IDLE && |req_valid) begin
                grant <= pick;
                last  <= pick;
            end
            if (hdr_wr) begin
                seq   <= seq + 7'd1;
                count <= '0;
`ifdef FT245_TX_ARB_TRAILER_EN
                csum  <= '0;
`endif
            end
            if (xfer) begin
                count <= count_inc;
`ifdef FT245_TX_ARB_TRAILER_EN
                csum  <= csum ^ fold(data_arr[grant]);
`endif
                // An end-of-packet on the cut word still closes the packet.
                if (burst_end) begin
                    cont[grant] <= !req_last[grant];
                end
            end
        end
    end

endmodule
